// File: rtl/uart_peek_pkg.sv
// Shared definitions for the memory-peek UART command path (receive and transmit).
package uart_peek_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    ID   = 3'd2,
    CSUM = 3'd3,
    HOLD = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DFLT = 8'hA5;

  // sync + 4 address bytes + id byte; the checksum byte trails the frame
  localparam int FRAME_LEN = 6;
  localparam int ADDR_BYTES = FRAME_LEN - 2;

  // XOR of the payload bytes (sync excluded)
  function automatic logic [7:0] frame_csum(input logic [31:0] addr, input logic [7:0] id);
    return addr[7:0] ^ addr[15:8] ^ addr[23:16] ^ addr[31:24] ^ id;
  endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap timer: counts idle cycles inside a frame and flags expiry.
module rx_gap_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise advance while enabled and park at the last value
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_peek_cmd_rx.sv
// Parses framed peek commands from the UART byte stream and presents each
// valid (address, id) pair on a valid/ready handshake.
module uart_peek_cmd_rx
  import uart_peek_pkg::*;
#(
  parameter int         NUM_CORES      = 16,
  parameter int         ID_W           = 4,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DFLT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            cmd_valid,
  input  logic            cmd_ready,
  output logic [31:0]     cmd_address,
  output logic [ID_W-1:0] cmd_id,
  output logic            frame_err,
  output logic            overrun,
  output logic [7:0]      err_count
);

  localparam logic [1:0] LAST_IDX    = 2'(ADDR_BYTES - 1);
  localparam logic [8:0] NUM_CORES_W = 9'(NUM_CORES);

  state_t          state_q;
  logic [1:0]      idx_q;
  logic [31:0]     addr_q;
  logic [7:0]      id_q;
  logic            cmd_valid_q;
  logic [31:0]     cmd_address_q;
  logic [ID_W-1:0] cmd_id_q;
  logic            frame_err_q;
  logic            overrun_q;
  logic [7:0]      err_count_q;

  logic in_frame;
  logic gap_expired;
  logic timeout_hit;
  logic frame_ok;

  // Saturating error counter increment; holds at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_frame    = (state_q == ADDR) || (state_q == ID) || (state_q == CSUM);
  assign timeout_hit = in_frame && gap_expired && !rx_valid;
  assign frame_ok    = (frame_csum(addr_q, id_q) == rx_data) &&
                       ({1'b0, id_q} < NUM_CORES_W);

  // The counter rests at zero outside a frame and restarts on every byte
  rx_gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (rx_valid || !in_frame),
    .enable_i (in_frame),
    .expired_o(gap_expired)
  );

  // Frame parser, command hold and error reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      addr_q        <= '0;
      id_q          <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_address_q <= '0;
      cmd_id_q      <= '0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
      err_count_q   <= '0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (timeout_hit) begin
        frame_err_q <= 1'b1;
        err_count_q <= sat_inc8(err_count_q);
        state_q     <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
              state_q <= ADDR;
              idx_q   <= '0;
            end
          end
          ADDR: begin
            // a sync value here is ordinary address data
            if (rx_valid) begin
              addr_q[{idx_q, 3'b000} +: 8] <= rx_data;
              idx_q <= idx_q + 2'd1;
              if (idx_q == LAST_IDX) begin
                state_q <= ID;
              end
            end
          end
          ID: begin
            if (rx_valid) begin
              id_q    <= rx_data;
              state_q <= CSUM;
            end
          end
          CSUM: begin
            if (rx_valid) begin
              if (frame_ok) begin
                cmd_address_q <= addr_q;
                cmd_id_q      <= id_q[ID_W-1:0];
                cmd_valid_q   <= 1'b1;
                state_q       <= HOLD;
              end else begin
                frame_err_q <= 1'b1;
                err_count_q <= sat_inc8(err_count_q);
                state_q     <= IDLE;
              end
            end
          end
          HOLD: begin
            if (cmd_valid_q && cmd_ready) begin
              cmd_valid_q <= 1'b0;
              // a sync byte arriving with the handshake starts the next frame
              if (rx_valid && (rx_data == SYNC_BYTE)) begin
                state_q <= ADDR;
                idx_q   <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else if (rx_valid) begin
              overrun_q <= 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_address = cmd_address_q;
  assign cmd_id      = cmd_id_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign err_count   = err_count_q;

endmodule
